// File: rtl/sound_latch_ctrl.sv
// M68K-to-Z80 sound command latch with a free-running Z80 timer interrupt.
// Define SOUND_LATCH_FIFO_EN to replace the single latch register with a 4-entry FIFO.
module sound_latch_ctrl #(
    parameter int unsigned IRQ_DIV = 187500
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       sound_latch_cs,
    input  logic       m68k_rw,
    input  logic       m68k_lds_n,
    input  logic [7:0] m68k_din,
    input  logic       z80_latch_r_cs,
    input  logic       z80_latch_clr_cs,
    input  logic       z80_rd_n,
    input  logic       z80_wr_n,
    input  logic       M1_n,
    input  logic       IORQ_n,
    output logic [7:0] z80_dout,
    output logic       z80_int_n,
    output logic       latch_pending
);

    if (IRQ_DIV < 2 || IRQ_DIV > 1048575) begin : g_bad_irq_div
        $error("IRQ_DIV must lie in 2..2^20-1");
    end

    localparam logic [19:0] TermCnt = 20'(IRQ_DIV - 1);

    // Bus strobes and their one-shot rising-edge events
    logic wr_lvl, rd_lvl, clr_lvl;
    logic wr_q, rd_q, clr_q;
    logic wr_ev, rd_ev, clr_ev;

    assign wr_lvl  = sound_latch_cs & ~m68k_rw & ~m68k_lds_n;
    assign rd_lvl  = z80_latch_r_cs & ~z80_rd_n;
    assign clr_lvl = z80_latch_clr_cs & ~z80_wr_n;

    assign wr_ev  = wr_lvl & ~wr_q;
    assign rd_ev  = rd_lvl & ~rd_q;
    assign clr_ev = clr_lvl & ~clr_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            wr_q  <= wr_lvl;
            rd_q  <= rd_lvl;
            clr_q <= clr_lvl;
        end
    end

    // Timer and interrupt
    logic [19:0] timer_q, timer_d;
    logic        irq_q, irq_d;
    logic        term_cnt, int_ack;

    assign term_cnt = (timer_q == TermCnt);
    assign int_ack  = ~M1_n & ~IORQ_n;

    always_comb begin
        timer_d = term_cnt ? 20'd0 : timer_q + 20'd1;
        irq_d   = irq_q;
        // Terminal count wins over a coincident acknowledge
        if (term_cnt) begin
            irq_d = 1'b1;
        end else if (int_ack) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= 20'd0;
            irq_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            irq_q   <= irq_d;
        end
    end

    assign z80_int_n = ~irq_q;

`ifdef SOUND_LATCH_FIFO_EN
    logic [7:0] fifo_q [4];
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] wr_addr;
    logic [2:0] cnt_q, cnt_d;
    logic       push;

    // Clear first, then pop, then push into whatever room remains
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        push     = 1'b0;
        if (clr_ev) begin
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
            cnt_d    = 3'd0;
        end else if (rd_ev && cnt_q != 3'd0) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
            cnt_d    = cnt_q - 3'd1;
        end
        wr_addr = wr_ptr_d;
        if (wr_ev && cnt_d != 3'd4) begin
            push     = 1'b1;
            wr_ptr_d = wr_ptr_d + 2'd1;
            cnt_d    = cnt_d + 3'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= 8'h00;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            if (clr_ev) begin
                for (int i = 0; i < 4; i++) begin
                    fifo_q[i] <= 8'h00;
                end
            end
            if (push) begin
                fifo_q[wr_addr] <= m68k_din;
            end
        end
    end

    assign latch_pending = (cnt_q != 3'd0);
    assign z80_dout      = (cnt_q == 3'd0) ? 8'h00 : fifo_q[rd_ptr_q];
`else
    logic [7:0] data_q, data_d;
    logic       pend_q, pend_d;

    // Clear, then read, then write: a coincident write always leaves new data pending
    always_comb begin
        data_d = data_q;
        pend_d = pend_q;
        if (clr_ev) begin
            data_d = 8'h00;
            pend_d = 1'b0;
        end
        if (rd_ev) begin
            pend_d = 1'b0;
        end
        if (wr_ev) begin
            data_d = m68k_din;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= 8'h00;
            pend_q <= 1'b0;
        end else begin
            data_q <= data_d;
            pend_q <= pend_d;
        end
    end

    assign latch_pending = pend_q;
    assign z80_dout      = data_q;
`endif

endmodule

// File: tb/tb_sound_latch_ctrl.sv
// Bench for sound_latch_ctrl: cycle model plus directed literal checks.
// Honours SOUND_LATCH_FIFO_EN the same way as the design.
module tb_sound_latch_ctrl;

    localparam int unsigned IrqDiv = 8;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       sound_latch_cs = 1'b0;
    logic       m68k_rw = 1'b1;
    logic       m68k_lds_n = 1'b1;
    logic [7:0] m68k_din = 8'h00;
    logic       z80_latch_r_cs = 1'b0;
    logic       z80_latch_clr_cs = 1'b0;
    logic       z80_rd_n = 1'b1;
    logic       z80_wr_n = 1'b1;
    logic       M1_n = 1'b1;
    logic       IORQ_n = 1'b1;
    logic [7:0] z80_dout;
    logic       z80_int_n;
    logic       latch_pending;

    sound_latch_ctrl #(.IRQ_DIV(IrqDiv)) dut (
        .clk_sys          (clk_sys),
        .reset_n          (reset_n),
        .sound_latch_cs   (sound_latch_cs),
        .m68k_rw          (m68k_rw),
        .m68k_lds_n       (m68k_lds_n),
        .m68k_din         (m68k_din),
        .z80_latch_r_cs   (z80_latch_r_cs),
        .z80_latch_clr_cs (z80_latch_clr_cs),
        .z80_rd_n         (z80_rd_n),
        .z80_wr_n         (z80_wr_n),
        .M1_n             (M1_n),
        .IORQ_n           (IORQ_n),
        .z80_dout         (z80_dout),
        .z80_int_n        (z80_int_n),
        .latch_pending    (latch_pending)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;
    bit done     = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // Model: events are rising edges of the bus strobes seen at each clock;
    // the interrupt fires on every IrqDiv-th clock since reset.
    int         m_cycle = 0;
    bit         m_irq = 1'b0;
    bit         m_wr_prev = 1'b0, m_rd_prev = 1'b0, m_clr_prev = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         m_pend = 1'b0;
    logic [7:0] m_q[$];

    initial forever begin
        @(posedge clk_sys or negedge reset_n);
        if (!reset_n) begin
            m_cycle = 0; m_irq = 1'b0;
            m_wr_prev = 1'b0; m_rd_prev = 1'b0; m_clr_prev = 1'b0;
            m_data = 8'h00; m_pend = 1'b0; m_q.delete();
        end else begin
            bit wl, rl, cl, wr, rd, clr, tc;
            wl  = sound_latch_cs && !m68k_rw && !m68k_lds_n;
            rl  = z80_latch_r_cs && !z80_rd_n;
            cl  = z80_latch_clr_cs && !z80_wr_n;
            wr  = wl && !m_wr_prev;
            rd  = rl && !m_rd_prev;
            clr = cl && !m_clr_prev;
            m_wr_prev = wl; m_rd_prev = rl; m_clr_prev = cl;
            tc = (m_cycle % IrqDiv) == IrqDiv - 1;
            m_cycle++;
            if (tc) m_irq = 1'b1;
            else if (!M1_n && !IORQ_n) m_irq = 1'b0;
`ifdef SOUND_LATCH_FIFO_EN
            if (clr) m_q.delete();
            else if (rd && m_q.size() > 0) void'(m_q.pop_front());
            if (wr && m_q.size() < 4) m_q.push_back(m68k_din);
`else
            if (clr) begin m_data = 8'h00; m_pend = 1'b0; end
            if (rd) m_pend = 1'b0;
            if (wr) begin m_data = m68k_din; m_pend = 1'b1; end
`endif
        end
    end

    initial forever begin
        @(negedge clk_sys);
        if (!done) begin
            logic [7:0] e_dout;
            bit         e_pend;
`ifdef SOUND_LATCH_FIFO_EN
            e_dout = (m_q.size() > 0) ? m_q[0] : 8'h00;
            e_pend = m_q.size() > 0;
`else
            e_dout = m_data;
            e_pend = m_pend;
`endif
            chk("model dout", z80_dout, e_dout);
            chk("model pending", latch_pending, e_pend);
            chk("model int_n", z80_int_n, !m_irq);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_on(input logic [7:0] d);
        sound_latch_cs = 1'b1; m68k_rw = 1'b0; m68k_lds_n = 1'b0; m68k_din = d;
    endtask

    task automatic wr_off();
        sound_latch_cs = 1'b0; m68k_rw = 1'b1; m68k_lds_n = 1'b1;
    endtask

    // Strobes are held two cycles so a second action would be visible
    task automatic m68k_write(input logic [7:0] d);
        wr_on(d); tick(2); wr_off(); tick(1);
    endtask

    task automatic z80_read();
        z80_latch_r_cs = 1'b1; z80_rd_n = 1'b0; tick(2);
        z80_latch_r_cs = 1'b0; z80_rd_n = 1'b1; tick(1);
    endtask

    task automatic z80_clear();
        z80_latch_clr_cs = 1'b1; z80_wr_n = 1'b0; tick(2);
        z80_latch_clr_cs = 1'b0; z80_wr_n = 1'b1; tick(1);
    endtask

    task automatic ack_one();
        M1_n = 1'b0; IORQ_n = 1'b0; tick(1);
        M1_n = 1'b1; IORQ_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        tick(3);
        chk("reset dout", z80_dout, 8'h00);
        chk("reset pending", latch_pending, 1'b0);
        chk("reset int_n", z80_int_n, 1'b1);
        reset_n = 1'b1;

        // Timer: clocks counted from reset release
        tick(7);
        chk("int before tc", z80_int_n, 1'b1);
        tick(1);
        chk("int at tc", z80_int_n, 1'b0);
        ack_one();
        chk("ack releases", z80_int_n, 1'b1);
        tick(6);
        ack_one();
        chk("tc beats ack", z80_int_n, 1'b0);
        tick(8);
        ack_one();
        chk("ack after tc", z80_int_n, 1'b1);
        tick(1);
        chk("tc not queued", z80_int_n, 1'b1);

        // Write then read
        m68k_write(8'h5A);
        chk("wr dout", z80_dout, 8'h5A);
        chk("wr pending", latch_pending, 1'b1);
        z80_latch_r_cs = 1'b1; z80_rd_n = 1'b0; #1;
        chk("dout in read", z80_dout, 8'h5A);
        tick(2);
        z80_latch_r_cs = 1'b0; z80_rd_n = 1'b1; tick(1);
        chk("rd pending", latch_pending, 1'b0);
`ifdef SOUND_LATCH_FIFO_EN
        chk("rd dout", z80_dout, 8'h00);
`else
        chk("rd dout kept", z80_dout, 8'h5A);
`endif

        // Two writes, no read
        z80_clear();
        m68k_write(8'h11);
        m68k_write(8'h22);
`ifdef SOUND_LATCH_FIFO_EN
        chk("two wr head", z80_dout, 8'h11);
        z80_read();
        chk("two wr second", z80_dout, 8'h22);
        z80_read();
        chk("two wr empty", latch_pending, 1'b0);
`else
        chk("two wr dout", z80_dout, 8'h22);
        chk("two wr pending", latch_pending, 1'b1);
`endif

        // Write coinciding with clear
        m68k_write(8'h77);
        wr_on(8'h33); z80_latch_clr_cs = 1'b1; z80_wr_n = 1'b0;
        tick(2);
        wr_off(); z80_latch_clr_cs = 1'b0; z80_wr_n = 1'b1;
        tick(1);
        chk("wr+clr dout", z80_dout, 8'h33);
        chk("wr+clr pending", latch_pending, 1'b1);

        // Write coinciding with read
        wr_on(8'h44); z80_latch_r_cs = 1'b1; z80_rd_n = 1'b0;
        tick(2);
        wr_off(); z80_latch_r_cs = 1'b0; z80_rd_n = 1'b1;
        tick(1);
        chk("wr+rd dout", z80_dout, 8'h44);
        chk("wr+rd pending", latch_pending, 1'b1);

        z80_clear();
        chk("clr dout", z80_dout, 8'h00);
        chk("clr pending", latch_pending, 1'b0);

`ifdef SOUND_LATCH_FIFO_EN
        // Overflow drops the fifth write
        for (int i = 1; i <= 5; i++) m68k_write(8'(i));
        for (int i = 1; i <= 4; i++) begin
            chk("ovf read", z80_dout, 32'(i));
            z80_read();
        end
        chk("ovf pending", latch_pending, 1'b0);
        chk("ovf dout", z80_dout, 8'h00);

        // Push and pop together on a full FIFO
        for (int i = 1; i <= 4; i++) m68k_write(8'(i));
        wr_on(8'h09); z80_latch_r_cs = 1'b1; z80_rd_n = 1'b0;
        tick(2);
        wr_off(); z80_latch_r_cs = 1'b0; z80_rd_n = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_seq [4];
            exp_seq = '{8'h02, 8'h03, 8'h04, 8'h09};
            chk("full push+pop", z80_dout, exp_seq[i]);
            z80_read();
        end
        chk("full drained", latch_pending, 1'b0);
`endif

        // Asynchronous reset with data and interrupt pending
        m68k_write(8'h66);
        for (int i = 0; i < 20 && z80_int_n; i++) tick(1);
        chk("irq wait", z80_int_n, 1'b0);
        chk("pre-reset pending", latch_pending, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst int_n", z80_int_n, 1'b1);
        chk("async rst pending", latch_pending, 1'b0);
        chk("async rst dout", z80_dout, 8'h00);
        wr_on(8'h99);
        tick(2);
        wr_off();
        tick(1);
        reset_n = 1'b1;
        tick(2);
        chk("post rst dout", z80_dout, 8'h00);
        chk("post rst pending", latch_pending, 1'b0);

        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sound_latch_ctrl.md
SOUND_LATCH_CTRL -- requirements
Module: sound_latch_ctrl

Interface
REQ-001 Parameter IRQ_DIV, default 187500, is the number of clk_sys cycles per Z80 timer interrupt (24 MHz / 128 Hz); legal range 2..2^20-1.
REQ-002 Port clk_sys, input, 1, system clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1, reset: asynchronous assertion, active-low.
REQ-004 Port sound_latch_cs, input, 1, M68K sound-latch select from the chip-select decoder.
REQ-005 Port m68k_rw, input, 1, M68K read/write: 1 = read, 0 = write.
REQ-006 Port m68k_lds_n, input, 1, M68K lower data strobe, active-low.
REQ-007 Port m68k_din, input, 8, M68K data bus bits 7:0.
REQ-008 Port z80_latch_r_cs, input, 1, Z80 I/O select for latch read (port 0x06).
REQ-009 Port z80_latch_clr_cs, input, 1, Z80 I/O select for latch clear (port 0x04).
REQ-010 Port z80_rd_n, input, 1, Z80 read strobe, active-low.
REQ-011 Port z80_wr_n, input, 1, Z80 write strobe, active-low.
REQ-012 Port M1_n, input, 1, Z80 M1, active-low.
REQ-013 Port IORQ_n, input, 1, Z80 IORQ, active-low.
REQ-014 Port z80_dout, output, 8, latch data presented to the Z80.
REQ-015 Port z80_int_n, output, 1, Z80 maskable interrupt, active-low level.
REQ-016 Port latch_pending, output, 1, high while unread command data is held.

Function
REQ-017 An M68K write strobe is defined as (sound_latch_cs & ~m68k_rw & ~m68k_lds_n); the block shall act once, on the first clk_sys cycle in which the registered strobe goes 0->1.
REQ-018 A Z80 read event is the 0->1 edge of (z80_latch_r_cs & ~z80_rd_n); a Z80 clear event is the 0->1 edge of (z80_latch_clr_cs & ~z80_wr_n).
REQ-019 Single-register mode: a write loads m68k_din into the latch and sets latch_pending the next cycle; a write while pending overwrites the data.
REQ-020 z80_dout shall continuously present the current latch or FIFO-head value; it is combinational from registered state, so data is valid during the read.
REQ-021 A read event shall clear latch_pending; in single-register mode the data is retained.
REQ-022 A clear event shall zero the data and clear latch_pending.
REQ-023 Simultaneous write and clear: the clear applies first, then the write, so the latch holds the new data and is pending.
REQ-024 Simultaneous write and read: the read consumes the old value and the new value becomes pending.
REQ-025 Timer: a 20-bit counter counts 0..IRQ_DIV-1 and wraps; at terminal count z80_int_n goes low the next cycle.
REQ-026 z80_int_n shall stay low until acknowledged, i.e. the first cycle with M1_n=0 and IORQ_n=0; it returns high the following cycle.
REQ-027 Terminal count and acknowledge in the same cycle: the set wins, so z80_int_n stays low.
REQ-028 A terminal count while the interrupt is already pending shall not be queued.

Reset
REQ-029 While reset_n=0: data and all FIFO entries = 8'h00, latch_pending=0, z80_dout=8'h00, z80_int_n=1, timer=0, edge-detect registers=0, FIFO pointers=0.
REQ-030 Reset mid-operation shall discard pending data and any pending interrupt immediately, with no partial write completing.

Configuration
REQ-031 Macro SOUND_LATCH_FIFO_EN: when defined, the latch is a 4-entry FIFO; when undefined, single-register behaviour per REQ-019..REQ-024 applies.
REQ-032 FIFO mode: a write pushes; a write when full is dropped; a read event pops the head; a clear empties the FIFO; latch_pending = not empty.
REQ-033 FIFO mode: z80_dout = head entry, or 8'h00 when empty; simultaneous push and pop on a full FIFO performs both.

Verification
REQ-034 Write 0x5A, then Z80 read -> z80_dout=0x5A, latch_pending goes 1 then 0 after the read edge.
REQ-035 Write 0x11 then 0x22 with no read -> single mode: dout=0x22; FIFO mode: reads return 0x11 then 0x22.
REQ-036 FIFO mode: 5 writes 0x01..0x05 -> 4 reads return 0x01..0x04, then latch_pending=0 and dout=0x00.
REQ-037 Write 0x33 and a clear event in the same cycle -> dout=0x33, latch_pending=1.
REQ-038 IRQ_DIV=8 -> z80_int_n falls every 8 cycles; an ack (M1_n=IORQ_n=0) releases it; an ack coinciding with terminal count leaves it low.
REQ-039 Assert reset_n=0 while pending with the interrupt low -> z80_int_n=1, latch_pending=0, dout=0x00 without waiting for a clock.
